// File: rtl/cdb_reservation_station.sv
// ---------------------------------------------------------------------------
// cdb_reservation_station
//   Consumer end of the common data bus. Holds up to four issued instructions,
//   snoops the 16-bit cdb word for pending operands, dispatches ready entries
//   to a single ULA and frees an entry when its own result is broadcast.
//
//   Optional build macro: RS_OLDEST_FIRST_EN
//     defined   : per-entry 2-bit age, dispatch picks the oldest ready entry
//                 (ties to lowest index)
//     undefined : no age storage, lowest ready index wins
//
// Ports
//   clock, reset            posedge clock, synchronous active-high reset
//   issue_valid/ready       issue handshake; ready while a slot is free
//   issue_op/dest           opcode, one-hot destination {R0,R1,R2}
//   issue_vj/qj, vk/qk      operand values and tags {pending, ula_id, slot}
//   issue_slot              slot taken by an accepted issue (combinational)
//   cdb                     bus word {dest[2:0], slot[1:0], ula_id, data[9:0]}
//   exec_valid/ready        dispatch handshake to the ULA
//   exec_op/a/b/dest/slot   selected entry contents (0 when nothing ready)
//   busy_count              occupied entries, 0..4
// ---------------------------------------------------------------------------

// One reservation-station slot: operand capture, issue bypass, dispatch and
// retire flags.
module cdb_rs_entry #(
   parameter int OP_W = 3
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            load,
   input  logic [OP_W-1:0] load_op,
   input  logic [2:0]      load_dest,
   input  logic [9:0]      load_vj,
   input  logic [3:0]      load_qj,
   input  logic [9:0]      load_vk,
   input  logic [3:0]      load_qk,
   input  logic            cdb_new,
   input  logic [2:0]      bc_tag,
   input  logic [9:0]      bc_data,
   input  logic            dispatch,
   input  logic            retire,
   output logic            busy,
   output logic            dispatched,
   output logic [OP_W-1:0] op,
   output logic [2:0]      dest,
   output logic [9:0]      vj,
   output logic [9:0]      vk,
   output logic            j_pend,
   output logic            k_pend
);

   logic [2:0] j_tag, k_tag;
   logic       j_hit, k_hit, load_j_hit, load_k_hit;

   assign j_hit      = cdb_new && busy && j_pend && (j_tag == bc_tag);
   assign k_hit      = cdb_new && busy && k_pend && (k_tag == bc_tag);
   // A tag arriving on the bus in the very cycle it is issued is taken as data.
   assign load_j_hit = cdb_new && load_qj[3] && (load_qj[2:0] == bc_tag);
   assign load_k_hit = cdb_new && load_qk[3] && (load_qk[2:0] == bc_tag);

   always_ff @(posedge clock) begin
      if (reset) begin
         busy       <= 1'b0;
         dispatched <= 1'b0;
         op         <= '0;
         dest       <= '0;
         vj         <= '0;
         vk         <= '0;
         j_pend     <= 1'b0;
         k_pend     <= 1'b0;
         j_tag      <= '0;
         k_tag      <= '0;
      end else if (load) begin
         // load only targets a free slot, so it never overlaps the busy paths
         busy       <= 1'b1;
         dispatched <= 1'b0;
         op         <= load_op;
         dest       <= load_dest;
         j_tag      <= load_qj[2:0];
         k_tag      <= load_qk[2:0];
         vj         <= load_j_hit ? bc_data : load_vj;
         j_pend     <= load_qj[3] && !load_j_hit;
         vk         <= load_k_hit ? bc_data : load_vk;
         k_pend     <= load_qk[3] && !load_k_hit;
      end else begin
         if (retire) begin
            busy       <= 1'b0;
            dispatched <= 1'b0;
         end
         if (dispatch) dispatched <= 1'b1;
         if (j_hit) begin
            vj     <= bc_data;
            j_pend <= 1'b0;
         end
         if (k_hit) begin
            vk     <= bc_data;
            k_pend <= 1'b0;
         end
      end
   end

endmodule

module cdb_reservation_station #(
   parameter logic ULA_ID = 1'b1,
   parameter int   OP_W   = 3
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            issue_valid,
   output logic            issue_ready,
   input  logic [OP_W-1:0] issue_op,
   input  logic [2:0]      issue_dest,
   input  logic [9:0]      issue_vj,
   input  logic [3:0]      issue_qj,
   input  logic [9:0]      issue_vk,
   input  logic [3:0]      issue_qk,
   output logic [1:0]      issue_slot,
   input  logic [15:0]     cdb,
   output logic            exec_valid,
   input  logic            exec_ready,
   output logic [OP_W-1:0] exec_op,
   output logic [9:0]      exec_a,
   output logic [9:0]      exec_b,
   output logic [2:0]      exec_dest,
   output logic [1:0]      exec_slot,
   output logic [2:0]      busy_count
);

   localparam int NUM_ENT = 4;

   logic [NUM_ENT-1:0]           busy, dispatched, j_pend, k_pend;
   logic [NUM_ENT-1:0]           ready, load, dispatch, retire;
   logic [NUM_ENT-1:0][OP_W-1:0] e_op;
   logic [NUM_ENT-1:0][2:0]      e_dest;
   logic [NUM_ENT-1:0][9:0]      e_vj, e_vk;

   logic [15:0] cdb_last;
   logic        cdb_new;
   logic [2:0]  bc_tag;
   logic        issue_fire, exec_fire, any_ready;
   logic [1:0]  sel;

   // The bus holds its last word; only a changed word with a destination
   // counts as a broadcast, so a held word is acted on once.
   always_ff @(posedge clock) begin
      if (reset) cdb_last <= '0;
      else       cdb_last <= cdb;
   end

   assign cdb_new = (cdb != cdb_last) && (cdb[15:13] != 3'b000);
   assign bc_tag  = {cdb[10], cdb[12:11]};

   // lowest free slot; issue decisions use the pre-free state of this cycle
   always_comb begin
      logic found;
      found      = 1'b0;
      issue_slot = '0;
      for (int i = 0; i < NUM_ENT; i++) begin
         if (!busy[i] && !found) begin
            issue_slot = 2'(i);
            found      = 1'b1;
         end
      end
   end

   assign issue_ready = ~&busy;
   assign issue_fire  = issue_valid && issue_ready;

   always_comb begin
      for (int i = 0; i < NUM_ENT; i++)
         ready[i] = busy[i] && !dispatched[i] && !j_pend[i] && !k_pend[i];
   end

   assign any_ready = |ready;

`ifdef RS_OLDEST_FIRST_EN
   logic [NUM_ENT-1:0][1:0] age;
   logic [1:0]              sel_age;

   // strict '>' keeps the lower index on equal age
   always_comb begin
      logic found;
      found   = 1'b0;
      sel     = '0;
      sel_age = '0;
      for (int i = 0; i < NUM_ENT; i++) begin
         if (ready[i] && (!found || age[i] > sel_age)) begin
            sel     = 2'(i);
            sel_age = age[i];
            found   = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         age <= '0;
      end else if (issue_fire) begin
         for (int i = 0; i < NUM_ENT; i++) begin
            if (2'(i) == issue_slot)            age[i] <= 2'd0;
            else if (busy[i] && age[i] != 2'd3) age[i] <= age[i] + 2'd1;
         end
      end
   end
`else
   always_comb begin
      logic found;
      found = 1'b0;
      sel   = '0;
      for (int i = 0; i < NUM_ENT; i++) begin
         if (ready[i] && !found) begin
            sel   = 2'(i);
            found = 1'b1;
         end
      end
   end
`endif

   assign exec_valid = any_ready;
   assign exec_fire  = any_ready && exec_ready;
   assign exec_op    = any_ready ? e_op[sel]   : '0;
   assign exec_a     = any_ready ? e_vj[sel]   : '0;
   assign exec_b     = any_ready ? e_vk[sel]   : '0;
   assign exec_dest  = any_ready ? e_dest[sel] : '0;
   assign exec_slot  = any_ready ? sel         : '0;

   always_comb begin
      for (int i = 0; i < NUM_ENT; i++) begin
         load[i]     = issue_fire && (issue_slot == 2'(i));
         dispatch[i] = exec_fire && (sel == 2'(i));
         // only our ULA's result for an in-flight entry frees the slot
         retire[i]   = cdb_new && (cdb[10] == ULA_ID) && (cdb[12:11] == 2'(i))
                       && busy[i] && dispatched[i];
      end
   end

   always_comb begin
      busy_count = '0;
      for (int i = 0; i < NUM_ENT; i++)
         busy_count = busy_count + {2'b00, busy[i]};
   end

   for (genvar g = 0; g < NUM_ENT; g++) begin : g_ent
      cdb_rs_entry #(.OP_W(OP_W)) u_ent (
         .clock      (clock),
         .reset      (reset),
         .load       (load[g]),
         .load_op    (issue_op),
         .load_dest  (issue_dest),
         .load_vj    (issue_vj),
         .load_qj    (issue_qj),
         .load_vk    (issue_vk),
         .load_qk    (issue_qk),
         .cdb_new    (cdb_new),
         .bc_tag     (bc_tag),
         .bc_data    (cdb[9:0]),
         .dispatch   (dispatch[g]),
         .retire     (retire[g]),
         .busy       (busy[g]),
         .dispatched (dispatched[g]),
         .op         (e_op[g]),
         .dest       (e_dest[g]),
         .vj         (e_vj[g]),
         .vk         (e_vk[g]),
         .j_pend     (j_pend[g]),
         .k_pend     (k_pend[g])
      );
   end

endmodule

// File: tb/tb_cdb_reservation_station.sv
// ---------------------------------------------------------------------------
// tb_cdb_reservation_station
//   Directed scenarios followed by randomized traffic. Every cycle the DUT's
//   combinational outputs are compared with a slot-array reference model that
//   applies the station's rules (edge-detected broadcasts, capture, bypass,
//   dispatch, free, age) directly.
// ---------------------------------------------------------------------------
module tb_cdb_reservation_station;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        issue_valid = 1'b0;
   logic        issue_ready;
   logic [2:0]  issue_op = '0;
   logic [2:0]  issue_dest = '0;
   logic [9:0]  issue_vj = '0;
   logic [3:0]  issue_qj = '0;
   logic [9:0]  issue_vk = '0;
   logic [3:0]  issue_qk = '0;
   logic [1:0]  issue_slot;
   logic [15:0] cdb = '0;
   logic        exec_valid;
   logic        exec_ready = 1'b0;
   logic [2:0]  exec_op;
   logic [9:0]  exec_a, exec_b;
   logic [2:0]  exec_dest;
   logic [1:0]  exec_slot;
   logic [2:0]  busy_count;

   int n_chk = 0;
   int n_err = 0;

   cdb_reservation_station #(.ULA_ID(1'b1), .OP_W(3)) dut (
      .clock(clock), .reset(reset),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_op(issue_op), .issue_dest(issue_dest),
      .issue_vj(issue_vj), .issue_qj(issue_qj),
      .issue_vk(issue_vk), .issue_qk(issue_qk),
      .issue_slot(issue_slot), .cdb(cdb),
      .exec_valid(exec_valid), .exec_ready(exec_ready),
      .exec_op(exec_op), .exec_a(exec_a), .exec_b(exec_b),
      .exec_dest(exec_dest), .exec_slot(exec_slot),
      .busy_count(busy_count)
   );

   always #5 clock = ~clock;

   // reference model: one record per slot
   bit         m_busy[4], m_disp[4], m_jp[4], m_kp[4];
   logic [2:0] m_op[4], m_dest[4], m_jt[4], m_kt[4];
   logic [9:0] m_vj[4], m_vk[4];
   int         m_age[4];
   logic [15:0] m_last;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void m_clear();
      for (int i = 0; i < 4; i++) begin
         m_busy[i] = 0; m_disp[i] = 0; m_jp[i] = 0; m_kp[i] = 0;
         m_op[i] = '0; m_dest[i] = '0; m_jt[i] = '0; m_kt[i] = '0;
         m_vj[i] = '0; m_vk[i] = '0; m_age[i] = 0;
      end
      m_last = '0;
   endfunction

   // Called just after a falling edge with inputs set: check outputs against
   // the model, advance the model over the coming rising edge, wait a cycle.
   task automatic step();
      int nbusy, e_slot, e_sel, s;
      bit e_new, pb[4], pd[4];
      logic [2:0] tag;
      #1;
      nbusy = 0; e_slot = -1; e_sel = -1;
      for (int i = 0; i < 4; i++) begin
         if (m_busy[i]) nbusy++;
         else if (e_slot < 0) e_slot = i;
      end
      for (int i = 0; i < 4; i++) begin
         if (m_busy[i] && !m_disp[i] && !m_jp[i] && !m_kp[i]) begin
`ifdef RS_OLDEST_FIRST_EN
            if (e_sel < 0 || m_age[i] > m_age[e_sel]) e_sel = i;
`else
            if (e_sel < 0) e_sel = i;
`endif
         end
      end
      chk("busy_count", busy_count, nbusy);
      chk("issue_ready", issue_ready, nbusy < 4);
      if (nbusy < 4) chk("issue_slot", issue_slot, e_slot);
      chk("exec_valid", exec_valid, e_sel >= 0);
      if (e_sel >= 0) begin
         chk("exec_slot", exec_slot, e_sel);
         chk("exec_op", exec_op, m_op[e_sel]);
         chk("exec_a", exec_a, m_vj[e_sel]);
         chk("exec_b", exec_b, m_vk[e_sel]);
         chk("exec_dest", exec_dest, m_dest[e_sel]);
      end

      if (reset) begin
         m_clear();
      end else begin
         e_new = (cdb != m_last) && (cdb[15:13] != 3'b000);
         tag   = {cdb[10], cdb[12:11]};
         for (int i = 0; i < 4; i++) begin pb[i] = m_busy[i]; pd[i] = m_disp[i]; end
         for (int i = 0; i < 4; i++) begin
            if (pb[i] && e_new && m_jp[i] && m_jt[i] == tag) begin m_vj[i] = cdb[9:0]; m_jp[i] = 0; end
            if (pb[i] && e_new && m_kp[i] && m_kt[i] == tag) begin m_vk[i] = cdb[9:0]; m_kp[i] = 0; end
         end
         if (e_sel >= 0 && exec_ready) m_disp[e_sel] = 1;
         s = int'(cdb[12:11]);
         if (e_new && cdb[10] && pb[s] && pd[s]) m_busy[s] = 0;
         if (issue_valid && nbusy < 4) begin
            for (int i = 0; i < 4; i++)
               if (pb[i] && m_age[i] < 3) m_age[i]++;
            m_busy[e_slot] = 1; m_disp[e_slot] = 0; m_age[e_slot] = 0;
            m_op[e_slot] = issue_op; m_dest[e_slot] = issue_dest;
            m_jt[e_slot] = issue_qj[2:0]; m_kt[e_slot] = issue_qk[2:0];
            if (issue_qj[3] && e_new && issue_qj[2:0] == tag) begin m_vj[e_slot] = cdb[9:0]; m_jp[e_slot] = 0; end
            else begin m_vj[e_slot] = issue_vj; m_jp[e_slot] = issue_qj[3]; end
            if (issue_qk[3] && e_new && issue_qk[2:0] == tag) begin m_vk[e_slot] = cdb[9:0]; m_kp[e_slot] = 0; end
            else begin m_vk[e_slot] = issue_vk; m_kp[e_slot] = issue_qk[3]; end
         end
         m_last = cdb;
      end
      @(negedge clock);
   endtask

   task automatic iss(input logic [2:0] op, input logic [2:0] dest, input logic [9:0] vj,
                      input logic [3:0] qj, input logic [9:0] vk, input logic [3:0] qk);
      issue_valid = 1'b1; issue_op = op; issue_dest = dest;
      issue_vj = vj; issue_qj = qj; issue_vk = vk; issue_qk = qk;
   endtask

   task automatic do_reset();
      reset = 1'b1; issue_valid = 1'b0; exec_ready = 1'b0;
      step();
      reset = 1'b0;
   endtask

   initial begin
      m_clear();
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;

      // reset state
      #1;
      chk("rst_busy_count", busy_count, 0);
      chk("rst_exec_valid", exec_valid, 0);
      chk("rst_issue_ready", issue_ready, 1);
      chk("rst_exec_a", exec_a, 0);
      chk("rst_exec_b", exec_b, 0);
      chk("rst_exec_op", exec_op, 0);

      // basic issue -> dispatch -> free
      iss(3'd1, 3'b001, 10'd5, 4'b0000, 10'd7, 4'b0000);
      #1 chk("t1_slot", issue_slot, 0);
      step();
      issue_valid = 1'b0; exec_ready = 1'b1;
      #1;
      chk("t1_valid", exec_valid, 1);
      chk("t1_a", exec_a, 5);
      chk("t1_b", exec_b, 7);
      chk("t1_slot_out", exec_slot, 0);
      step();
      exec_ready = 1'b0; cdb = 16'h8405;
      step();
      #1 chk("t1_free", busy_count, 0);

      // held bus word captured once, dependent dispatches once
      iss(3'd2, 3'b010, 10'd9, 4'b0000, 10'd4, 4'b0000);
      step();
      iss(3'd3, 3'b100, 10'd0, 4'b1100, 10'd2, 4'b0000);
      #1 chk("t2_slot", issue_slot, 1);
      step();
      issue_valid = 1'b0; exec_ready = 1'b1;
      step();
      cdb = 16'h8403;
      step();
      #1;
      chk("t2_valid", exec_valid, 1);
      chk("t2_a", exec_a, 3);
      chk("t2_slot_out", exec_slot, 1);
      step();
      #1;
      chk("t2_once", exec_valid, 0);
      chk("t2_busy", busy_count, 1);
      step();
      cdb = 16'h8C00;
      step();
      #1 chk("t2_free", busy_count, 0);

      // issue bypass
      exec_ready = 1'b0;
      iss(3'd4, 3'b001, 10'd1, 4'b0000, 10'd0, 4'b1101);
      cdb = 16'h4D2A;
      step();
      issue_valid = 1'b0; exec_ready = 1'b1;
      #1;
      chk("t3_valid", exec_valid, 1);
      chk("t3_b", exec_b, 10'h12A);
      step();
      exec_ready = 1'b0; cdb = 16'h8405;
      step();
      #1 chk("t3_free", busy_count, 0);

      // full, dropped issue, free-cycle issue blocked, reuse of slot 2
      for (int k = 0; k < 4; k++) begin
         iss(3'(k), 3'b010, 10'(k + 20), 4'b0000, 10'(k + 30), 4'b0000);
         #1 chk("t4_fill_slot", issue_slot, k);
         step();
      end
      #1;
      chk("t4_full_ready", issue_ready, 0);
      iss(3'd7, 3'b001, 10'd99, 4'b0000, 10'd98, 4'b0000);
      step();
      #1 chk("t4_dropped", busy_count, 4);
      issue_valid = 1'b0; exec_ready = 1'b1;
      repeat (4) step();
      exec_ready = 1'b0;
      cdb = 16'h3411;
      iss(3'd5, 3'b100, 10'd55, 4'b0000, 10'd56, 4'b0000);
      #1 chk("t4_free_cycle_ready", issue_ready, 0);
      step();
      #1;
      chk("t4_reuse_ready", issue_ready, 1);
      chk("t4_reuse_slot", issue_slot, 2);
      step();
      issue_valid = 1'b0;
      #1 chk("t4_refill", busy_count, 4);
      step();

      // reset mid-operation
      do_reset();
      for (int k = 0; k < 3; k++) begin
         iss(3'd6, 3'b001, 10'd0, 4'b1110, 10'(k), 4'b0000);
         step();
      end
      issue_valid = 1'b0;
      #1 chk("t5_three", busy_count, 3);
      do_reset();
      cdb = 16'h3455;
      #1;
      chk("t5_count", busy_count, 0);
      chk("t5_valid", exec_valid, 0);
      step();
      iss(3'd2, 3'b010, 10'd0, 4'b1110, 10'd1, 4'b0000);
      step();
      issue_valid = 1'b0;
      #1 chk("t5_no_capture", exec_valid, 0);
      step();

      // selection order: A pending in slot 0, B ready in slot 1
      do_reset();
      iss(3'd1, 3'b001, 10'd0, 4'b1001, 10'd11, 4'b0000);
      step();
      iss(3'd2, 3'b010, 10'd22, 4'b0000, 10'd23, 4'b0000);
      step();
      issue_valid = 1'b0;
      cdb = 16'h2877;
      step();
      #1 chk("t6a_first", exec_slot, 0);
      step();

      // A in slot 1, B in slot 0
      do_reset();
      exec_ready = 1'b1;
      iss(3'd3, 3'b100, 10'd1, 4'b0000, 10'd2, 4'b0000);
      step();
      iss(3'd1, 3'b001, 10'd0, 4'b1001, 10'd11, 4'b0000);
      step();
      issue_valid = 1'b0; exec_ready = 1'b0;
      cdb = 16'h2411;
      step();
      iss(3'd2, 3'b010, 10'd22, 4'b0000, 10'd23, 4'b0000);
      #1 chk("t6b_slot", issue_slot, 0);
      step();
      issue_valid = 1'b0;
      cdb = 16'h2877;
      step();
`ifdef RS_OLDEST_FIRST_EN
      #1 chk("t6b_first", exec_slot, 1);
`else
      #1 chk("t6b_first", exec_slot, 0);
`endif
      exec_ready = 1'b1;
      step();
`ifdef RS_OLDEST_FIRST_EN
      #1 chk("t6b_second", exec_slot, 0);
`else
      #1 chk("t6b_second", exec_slot, 1);
`endif
      step();

      // randomized traffic
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         int r, n;
         int cand[$];
         reset = ($urandom_range(0, 199) == 0);
         issue_valid = ($urandom_range(0, 1) == 1);
         issue_op   = 3'($urandom);
         issue_dest = 3'($urandom);
         issue_vj   = 10'($urandom);
         issue_vk   = 10'($urandom);
         issue_qj   = {($urandom_range(0, 9) < 4), 3'($urandom)};
         issue_qk   = {($urandom_range(0, 9) < 4), 3'($urandom)};
         exec_ready = ($urandom_range(0, 9) < 6);
         r = $urandom_range(0, 99);
         if (r >= 30 && r < 65) begin
            cand.delete();
            for (int i = 0; i < 4; i++) if (m_busy[i] && m_disp[i]) cand.push_back(i);
            n = cand.size();
            if (n > 0)
               cdb = {3'($urandom_range(1, 7)), 2'(cand[$urandom_range(0, n - 1)]), 1'b1, 10'($urandom)};
            else
               cdb = 16'($urandom);
         end else if (r >= 65) begin
            cdb = 16'($urandom);
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
